spi_bus_arbiter: RTL and testbench

//  Shares the single SD/MMC SPI bus between the host control CPU (cfide side) and the Amiga core (minimig side).

---
 rtl/spi_arb_pkg.sv | 21 ++
 rtl/spi_shift_engine.sv | 118 +++++++++++
 rtl/spi_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SD/MMC SPI bus arbiter.
//   state_e : arbiter FSM states
//   owner_e : which master currently owns the bus
//   SPI_IDLE_MOSI : level driven on mosi whenever no byte is shifting
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWNED,
        ST_SHIFT,
        ST_GAP
    } state_e;

    typedef enum logic {
        OWN_HOST,
        OWN_AMI
    } owner_e;

    localparam logic SPI_IDLE_MOSI = 1'b1;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode 0 byte shifter, MSB first.
// Optional macro: SPI_RAW_ACK_EN -- every sck edge waits for a spi_raw_ack
// toggle before the half-period divider restarts (and the byte only completes
// after the ack following the last edge).
// Ports:
//   sysclk, reset        clock, async active-high reset
//   start, txd           begin shifting txd (ignored while busy)
//   rxd, done            received byte, 1-cycle completion pulse
//   busy                 byte in progress
//   sck, mosi, miso      SPI pins
//   spi_raw_ack          per-edge handshake from the CPLD mux
module spi_shift_engine
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] txd,
    output logic [7:0] rxd,
    output logic       done,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    input  logic       spi_raw_ack
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q;
    logic [4:0]    edge_q;
    logic [7:0]    tx_q, rx_q;
    logic          busy_q, sck_q, mosi_q, done_q, wait_q;
    logic          ack_evt;

`ifdef SPI_RAW_ACK_EN
    logic ack_q;
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) ack_q <= 1'b0;
        else       ack_q <= spi_raw_ack;
    end
    assign ack_evt = spi_raw_ack ^ ack_q;
`else
    logic unused_ack;
    assign unused_ack = spi_raw_ack;
    assign ack_evt    = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            edge_q <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= SPI_IDLE_MOSI;
            done_q <= 1'b0;
            wait_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start) begin
                    // One extra setup cycle before the first rising edge.
                    busy_q <= 1'b1;
                    sck_q  <= 1'b0;
                    mosi_q <= txd[7];
                    tx_q   <= txd;
                    cnt_q  <= CW'(CLK_DIV);
                    edge_q <= '0;
                    wait_q <= 1'b0;
                end
            end else if (wait_q) begin
                if (ack_evt) begin
                    wait_q <= 1'b0;
                    if (edge_q == 5'd16) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        mosi_q <= SPI_IDLE_MOSI;
                    end else begin
                        cnt_q <= CW'(CLK_DIV - 1);
                    end
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                edge_q <= edge_q + 1'b1;
                sck_q  <= ~sck_q;
                if (!sck_q) begin
                    rx_q <= {rx_q[6:0], miso};
                end else begin
                    tx_q   <= {tx_q[6:0], 1'b0};
                    mosi_q <= tx_q[6];
                end
`ifdef SPI_RAW_ACK_EN
                wait_q <= 1'b1;
`else
                if (edge_q == 5'd15) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    mosi_q <= SPI_IDLE_MOSI;
                end else begin
                    cnt_q <= CW'(CLK_DIV - 1);
                end
`endif
            end
        end
    end

    assign rxd  = rx_q;
    assign done = done_q;
    assign busy = busy_q;
    assign sck  = sck_q;
    assign mosi = mosi_q;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SD/MMC SPI bus between the host CPU (h_*) and the Amiga core (a_*).
// Grants per transaction, muxes chip selects from the owner, runs byte shifts
// through spi_shift_engine. Optional macro SPI_RAW_ACK_EN (see engine).
// Ports: sysclk/reset; per side req/gnt/start/txd/cs/rxd/done; busy;
//        sck/mosi/miso/cs_n SPI pins; spi_raw_ack handshake.
//
//   state    | meaning
//   ST_IDLE  | no owner, arbitrate pending requests
//   ST_OWNED | owner holds cs, waits for start / release / timeout
//   ST_SHIFT | byte in flight, cs frozen
//   ST_GAP   | all cs_n high for CS_GAP cycles between owners
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int NCS          = 3,
    parameter int CS_GAP       = 2,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int HOST_PRIO    = 1
) (
    input  logic           sysclk,
    input  logic           reset,
    input  logic           h_req,
    output logic           h_gnt,
    input  logic           h_start,
    input  logic [7:0]     h_txd,
    input  logic [NCS-1:0] h_cs,
    output logic [7:0]     h_rxd,
    output logic           h_done,
    input  logic           a_req,
    output logic           a_gnt,
    input  logic           a_start,
    input  logic [7:0]     a_txd,
    input  logic [NCS-1:0] a_cs,
    output logic [7:0]     a_rxd,
    output logic           a_done,
    output logic           busy,
    output logic           sck,
    output logic           mosi,
    input  logic           miso,
    output logic [NCS-1:0] cs_n,
    input  logic           spi_raw_ack
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(IDLE_TIMEOUT);
    localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);

    state_e         state_q, state_d;
    owner_e         owner_q, owner_d, last_q, last_d;
    logic           revoked_q, revoked_d;
    logic [TW-1:0]  to_q, to_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [NCS-1:0] cs_frz_q, cs_frz_d;
    logic [7:0]     h_rxd_q, a_rxd_q;

    logic           own_req, oth_req, own_start, to_hit, owned, eng_start;
    logic           eng_done;
    logic [7:0]     own_txd, eng_rxd;
    logic [NCS-1:0] own_cs;

    assign own_req   = (owner_q == OWN_HOST) ? h_req   : a_req;
    assign oth_req   = (owner_q == OWN_HOST) ? a_req   : h_req;
    assign own_start = (owner_q == OWN_HOST) ? h_start : a_start;
    assign own_txd   = (owner_q == OWN_HOST) ? h_txd   : a_txd;
    assign own_cs    = (owner_q == OWN_HOST) ? h_cs    : a_cs;
    assign to_hit    = oth_req && (to_q == '0);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        revoked_d = revoked_q;
        to_d      = to_q;
        gap_d     = gap_q;
        cs_frz_d  = cs_frz_q;
        eng_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                to_d = TO_LOAD;
                if (h_req || a_req) begin
                    state_d   = ST_OWNED;
                    revoked_d = 1'b0;
                    if (h_req && a_req) begin
                        // A revoked owner must not win straight back, or a
                        // timeout could never hand the bus over.
                        if (revoked_q || HOST_PRIO == 0)
                            owner_d = (last_q == OWN_HOST) ? OWN_AMI : OWN_HOST;
                        else
                            owner_d = OWN_HOST;
                    end else begin
                        owner_d = h_req ? OWN_HOST : OWN_AMI;
                    end
                end
            end
            ST_OWNED: begin
                if (!own_req || to_hit) begin
                    state_d   = ST_GAP;
                    gap_d     = GAP_LOAD;
                    last_d    = owner_q;
                    revoked_d = own_req;
                end else if (own_start) begin
                    state_d   = ST_SHIFT;
                    eng_start = 1'b1;
                    to_d      = TO_LOAD;
                    cs_frz_d  = own_cs;
                end else if (oth_req) begin
                    to_d = to_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (eng_done) begin
                    if (own_req) begin
                        state_d = ST_OWNED;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                        last_d  = owner_q;
                    end
                end
            end
            default: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_HOST;
            last_q    <= OWN_AMI;
            revoked_q <= 1'b0;
            to_q      <= TO_LOAD;
            gap_q     <= '0;
            cs_frz_q  <= '0;
            h_rxd_q   <= '0;
            a_rxd_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            revoked_q <= revoked_d;
            to_q      <= to_d;
            gap_q     <= gap_d;
            cs_frz_q  <= cs_frz_d;
            if (h_done) h_rxd_q <= eng_rxd;
            if (a_done) a_rxd_q <= eng_rxd;
        end
    end

    spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_eng (
        .sysclk      (sysclk),
        .reset       (reset),
        .start       (eng_start),
        .txd         (own_txd),
        .rxd         (eng_rxd),
        .done        (eng_done),
        .busy        (busy),
        .sck         (sck),
        .mosi        (mosi),
        .miso        (miso),
        .spi_raw_ack (spi_raw_ack)
    );

    // Grant drops in the same cycle as a release or revoke.
    assign owned  = (state_q == ST_SHIFT) || (state_q == ST_OWNED && own_req && !to_hit);
    assign h_gnt  = owned && (owner_q == OWN_HOST);
    assign a_gnt  = owned && (owner_q == OWN_AMI);
    assign h_done = eng_done && (owner_q == OWN_HOST);
    assign a_done = eng_done && (owner_q == OWN_AMI);
    assign h_rxd  = h_done ? eng_rxd : h_rxd_q;
    assign a_rxd  = a_done ? eng_rxd : a_rxd_q;

    always_comb begin
        case (state_q)
            ST_OWNED: cs_n = ~own_cs;
            ST_SHIFT: cs_n = ~cs_frz_q;
            default:  cs_n = '1;
        endcase
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with miso looped back to mosi.
// A second instance with HOST_PRIO=0 shares all inputs.
module tb_spi_bus_arbiter;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 2;
    localparam int IDLE_TO = 1024;
`ifdef SPI_RAW_ACK_EN
    localparam int BYTE_T = 16 * (CLK_DIV + 3) + 1;
`else
    localparam int BYTE_T = 16 * CLK_DIV + 1;
`endif

    logic       sysclk, reset;
    logic       h_req, h_start, a_req, a_start, spi_raw_ack;
    logic [7:0] h_txd, a_txd;
    logic [2:0] h_cs, a_cs;
    logic       h_gnt, h_done, a_gnt, a_done, busy, sck, mosi, miso;
    logic [7:0] h_rxd, a_rxd;
    logic [2:0] cs_n;

    logic       p0_h_gnt, p0_a_gnt, p0_mosi, p0_miso;
    logic       unused_p0_h_done, unused_p0_a_done, unused_p0_busy, unused_p0_sck;
    logic [7:0] unused_p0_h_rxd, unused_p0_a_rxd;
    logic [2:0] unused_p0_cs_n;

    assign miso    = mosi;
    assign p0_miso = p0_mosi;

    spi_bus_arbiter #(.CLK_DIV(CLK_DIV), .NCS(3), .CS_GAP(CS_GAP),
                      .IDLE_TIMEOUT(IDLE_TO), .HOST_PRIO(1)) u_dut (
        .sysclk(sysclk), .reset(reset),
        .h_req(h_req), .h_gnt(h_gnt), .h_start(h_start), .h_txd(h_txd), .h_cs(h_cs),
        .h_rxd(h_rxd), .h_done(h_done),
        .a_req(a_req), .a_gnt(a_gnt), .a_start(a_start), .a_txd(a_txd), .a_cs(a_cs),
        .a_rxd(a_rxd), .a_done(a_done),
        .busy(busy), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n),
        .spi_raw_ack(spi_raw_ack)
    );

    spi_bus_arbiter #(.CLK_DIV(CLK_DIV), .NCS(3), .CS_GAP(CS_GAP),
                      .IDLE_TIMEOUT(IDLE_TO), .HOST_PRIO(0)) u_rr (
        .sysclk(sysclk), .reset(reset),
        .h_req(h_req), .h_gnt(p0_h_gnt), .h_start(h_start), .h_txd(h_txd), .h_cs(h_cs),
        .h_rxd(unused_p0_h_rxd), .h_done(unused_p0_h_done),
        .a_req(a_req), .a_gnt(p0_a_gnt), .a_start(a_start), .a_txd(a_txd), .a_cs(a_cs),
        .a_rxd(unused_p0_a_rxd), .a_done(unused_p0_a_done),
        .busy(unused_p0_busy), .sck(unused_p0_sck), .mosi(p0_mosi), .miso(p0_miso),
        .cs_n(unused_p0_cs_n), .spi_raw_ack(spi_raw_ack)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int sck_rises = 0;
    always @(posedge sck) sck_rises++;

`ifdef SPI_RAW_ACK_EN
    // CPLD model: toggle ack so the arbiter sees it 3 cycles after each sck edge.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge sysclk);
            if (sck !== prev) begin
                prev = sck;
                @(posedge sysclk);
                @(posedge sysclk);
                @(negedge sysclk);
                spi_raw_ack = ~spi_raw_ack;
            end
        end
    end
`endif

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic start_byte(input bit host, input logic [7:0] d, input bit push);
        if (host) h_txd = d; else a_txd = d;
        if (push) exp_q.push_back(d);
        if (host) h_start = 1'b1; else a_start = 1'b1;
        tick();
        h_start = 1'b0;
        a_start = 1'b0;
    endtask

    task automatic wait_done(input bit host, output int n);
        logic [7:0] e;
        n = 0;
        while (n < 2000) begin
            tick();
            n++;
            if ((host ? h_done : a_done) === 1'b1) break;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(host ? "h_rxd" : "a_rxd", host ? h_rxd : a_rxd, e);
        end else begin
            chk("sb_underflow", exp_q.size(), 1);
        end
    endtask

    task automatic ticks_until_gnt(input bit host, output int n, output bit allhi);
        n = 0;
        allhi = 1'b1;
        while (n < 2000) begin
            tick();
            n++;
            if ((host ? h_gnt : a_gnt) === 1'b1) break;
            if (cs_n !== 3'b111) allhi = 1'b0;
        end
    endtask

    initial begin
        int n, m, base, dones;
        bit allhi;

        reset = 1'b1;
        h_req = 0; h_start = 0; h_txd = 0; h_cs = 0;
        a_req = 0; a_start = 0; a_txd = 0; a_cs = 0;
        spi_raw_ack = 1'b0;
        repeat (3) tick();
        chk("reset_ctl", {h_gnt, a_gnt, h_done, a_done, busy, sck, mosi, cs_n},
            {7'b0000001, 3'b111});
        chk("reset_rxd", {h_rxd, a_rxd}, 16'h0000);
        reset = 1'b0;
        tick();

        // Single host request: grant one cycle later, cs mux.
        h_req = 1'b1; h_cs = 3'b010;
        chk("gnt_latency_pre", h_gnt, 0);
        tick();
        chk("gnt_host", {h_gnt, a_gnt}, 2'b10);
        chk("cs_host", cs_n, 3'b101);

        // Host byte A5 with loopback.
        base = sck_rises;
        start_byte(1'b1, 8'hA5, 1'b1);
        chk("busy_on", busy, 1);
        wait_done(1'b1, n);
        chk("byte_time_A5", n, BYTE_T);
        chk("sck_rises", sck_rises - base, 8);
        tick();
        chk("cs_after_byte", cs_n, 3'b101);

        // Non-owner start is ignored.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        chk("nonowner_start", {busy, a_done}, 2'b00);

        // Host releases while Amiga waits: gap then Amiga grant.
        a_req = 1'b1; a_cs = 3'b100;
        h_req = 1'b0; h_cs = 3'b000;
        ticks_until_gnt(1'b0, n, allhi);
        chk("handover_ticks", n, CS_GAP + 2);
        chk("handover_gap_cs", allhi, 1);
        chk("handover_rr", p0_a_gnt, 1);
        chk("cs_ami", cs_n, 3'b011);

        start_byte(1'b0, 8'h5A, 1'b1);
        wait_done(1'b0, n);
        chk("byte_time_5A", n, BYTE_T);
        chk("h_rxd_hold", h_rxd, 8'hA5);
        a_req = 1'b0;
        repeat (6) tick();

        // Simultaneous requests with last owner = Amiga: host wins on both.
        h_req = 1'b1; a_req = 1'b1;
        tick();
        chk("simul_prio1", {h_gnt, a_gnt}, 2'b10);
        chk("simul_prio0", {p0_h_gnt, p0_a_gnt}, 2'b10);
        h_req = 1'b0; a_req = 1'b0;
        repeat (6) tick();
        // Last owner is now host: priority picks host, round-robin picks Amiga.
        h_req = 1'b1; a_req = 1'b1;
        tick();
        chk("simul2_prio1", {h_gnt, a_gnt}, 2'b10);
        chk("simul2_prio0", {p0_h_gnt, p0_a_gnt}, 2'b01);
        h_req = 1'b0; a_req = 1'b0;
        repeat (6) tick();

        // Idle owner revoked after IDLE_TO cycles while the other side waits.
        h_req = 1'b1;
        tick();
        a_req = 1'b1;
        n = 0;
        while (n < 2000) begin
            tick();
            n++;
            if (h_gnt !== 1'b1) break;
        end
        chk("revoke_ticks", n, IDLE_TO);
        ticks_until_gnt(1'b0, n, allhi);
        chk("revoke_handover", n, CS_GAP + 2);
        chk("revoke_gap_cs", allhi, 1);
        h_req = 1'b0; a_req = 1'b0;
        repeat (6) tick();

        // Same idle without a waiter: no revoke.
        h_req = 1'b1; h_cs = 3'b001;
        tick();
        repeat (1100) tick();
        chk("no_revoke", h_gnt, 1);

        // Release mid-byte: byte completes, then cs released.
        start_byte(1'b1, 8'h3C, 1'b1);
        repeat (29) tick();
        h_req = 1'b0;
        wait_done(1'b1, n);
        chk("middrop_time", n + 29, BYTE_T);
        tick();
        chk("middrop_cs", {h_gnt, cs_n}, 4'b0111);

        // Reset in the middle of a byte.
        h_req = 1'b1;
        ticks_until_gnt(1'b1, n, allhi);
        chk("regrant", h_gnt, 1);
        start_byte(1'b1, 8'hC3, 1'b0);
        repeat (20) tick();
        reset = 1'b1;
        h_req = 1'b0;
        #1;
        chk("midreset_ctl", {h_gnt, a_gnt, h_done, a_done, busy, sck, mosi, cs_n},
            {7'b0000001, 3'b111});
        chk("midreset_rxd", {h_rxd, a_rxd}, 16'h0000);
        repeat (3) tick();
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (h_done === 1'b1 || a_done === 1'b1) dones++;
        end
        chk("no_partial_done", dones, 0);
        m = exp_q.size();
        chk("sb_drained", m, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
